// File: rtl/maze_access_arbiter_if.sv
// Request/response and ROM bus of the maze access arbiter.
//   req         : per-requester lookup request level
//   xpos_bus    : requester i pixel x at [10i+9:10i]
//   ypos_bus    : requester i pixel y, same packing
//   rom_rd      : ROM read enable
//   rom_addr    : ROM tile address (row*MAZE_W + col)
//   rom_data    : wall bit, valid the cycle after rom_rd
//   ack         : one-hot one-cycle completion strobe
//   legal_moves : {down, up, right, left}, 1 = legal, valid with ack
//   busy        : arbiter is not idle
// master = requesters/ROM side, slave = arbiter.
interface maze_access_arbiter_if #(
    parameter int unsigned NREQ   = 5,
    parameter int unsigned ADDR_W = 10
);
    localparam int unsigned POS_W = 10;

    logic [NREQ-1:0]       req;
    logic [NREQ*POS_W-1:0] xpos_bus;
    logic [NREQ*POS_W-1:0] ypos_bus;
    logic                  rom_rd;
    logic [ADDR_W-1:0]     rom_addr;
    logic                  rom_data;
    logic [NREQ-1:0]       ack;
    logic [3:0]            legal_moves;
    logic                  busy;

    modport master (
        output req, xpos_bus, ypos_bus, rom_data,
        input  rom_rd, rom_addr, ack, legal_moves, busy
    );

    modport slave (
        input  req, xpos_bus, ypos_bus, rom_data,
        output rom_rd, rom_addr, ack, legal_moves, busy
    );
endinterface

// File: rtl/maze_access_arbiter.sv
// Shares the maze wall ROM between pacman and the ghosts: round-robin grant,
// pixel-to-tile conversion, four neighbour reads (L, R, U, D), and a one-cycle
// ack carrying the legal-move mask back to the winner.
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : maze_access_arbiter_if.slave (requests, ROM access, responses)
module maze_access_arbiter #(
    parameter int unsigned NREQ       = 5,
    parameter int unsigned MAZE_W     = 28,
    parameter int unsigned MAZE_H     = 31,
    parameter int unsigned TILE_SHIFT = 3,
    parameter int          X_ORG      = 0,
    parameter int          Y_ORG      = 0,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    maze_access_arbiter_if.slave  bus
);
    localparam int unsigned POS_W = 10;
    // two extra bits: sign plus headroom for positions below the origin
    localparam int unsigned CRD_W = POS_W + 2;
    localparam int unsigned ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic signed [CRD_W-1:0] X_ORG_S  = CRD_W'(X_ORG);
    localparam logic signed [CRD_W-1:0] Y_ORG_S  = CRD_W'(Y_ORG);
    localparam logic signed [CRD_W-1:0] MAZE_W_S = CRD_W'(MAZE_W);
    localparam logic signed [CRD_W-1:0] MAZE_H_S = CRD_W'(MAZE_H);
    localparam logic signed [CRD_W-1:0] ZERO_S   = CRD_W'(0);
    localparam logic signed [CRD_W-1:0] ONE_S    = CRD_W'(1);
    localparam logic [ID_W-1:0]         LAST_ID  = ID_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DRAIN,
        RESP
    } state_t;

    state_t                   state, state_d;
    logic [1:0]               idx, idx_d;
    logic [ID_W-1:0]          id, id_d;
    logic [ID_W-1:0]          rr_ptr, rr_ptr_d;
    logic signed [CRD_W-1:0]  col, col_d;
    logic signed [CRD_W-1:0]  row, row_d;
    logic [3:0]               mask, mask_d;
    logic                     rd_q;
    logic [1:0]               rd_idx_q;

    logic                     rom_rd_d;
    logic [ADDR_W-1:0]        rom_addr_d;
    logic [NREQ-1:0]          ack_d;
    logic [3:0]               legal_d;
    logic                     busy_d;

    logic [POS_W-1:0]         xpos_arr [NREQ];
    logic [POS_W-1:0]         ypos_arr [NREQ];
    logic                     found;
    logic [ID_W-1:0]          gnt;
    int                       cand;
    logic signed [CRD_W-1:0]  x_off, y_off;
    logic signed [CRD_W-1:0]  nb_col, nb_row;
    logic                     own_in, nb_in;

    // unpack the position buses per requester
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_pos
        assign xpos_arr[g] = bus.xpos_bus[g*POS_W +: POS_W];
        assign ypos_arr[g] = bus.ypos_bus[g*POS_W +: POS_W];
    end

    // round-robin search: first set req bit upward from rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = 0;
        for (int i = 0; i < int'(NREQ); i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= int'(NREQ)) begin
                cand = cand - int'(NREQ);
            end
            if (!found && bus.req[ID_W'(cand)]) begin
                found = 1'b1;
                gnt   = ID_W'(cand);
            end
        end
    end

    // next state, capture of read data and registered output values
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        id_d       = id;
        rr_ptr_d   = rr_ptr;
        col_d      = col;
        row_d      = row;
        mask_d     = mask;
        rom_rd_d   = 1'b0;
        rom_addr_d = bus.rom_addr;
        ack_d      = '0;
        legal_d    = '0;
        x_off      = '0;
        y_off      = '0;
        nb_col     = '0;
        nb_row     = '0;
        own_in     = 1'b0;
        nb_in      = 1'b0;

        // ROM data answers the read issued one cycle earlier
        if (rd_q) begin
            mask_d[rd_idx_q] = ~bus.rom_data;
        end

        case (state)
            IDLE: begin
                if (found) begin
                    id_d    = gnt;
                    x_off   = $signed({2'b00, xpos_arr[gnt]}) - X_ORG_S;
                    y_off   = $signed({2'b00, ypos_arr[gnt]}) - Y_ORG_S;
                    col_d   = x_off >>> TILE_SHIFT;
                    row_d   = y_off >>> TILE_SHIFT;
                    mask_d  = '0;
                    idx_d   = 2'd0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (idx == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx + 2'd1;
                end
            end
            DRAIN: begin
                state_d = RESP;
            end
            RESP: begin
                rr_ptr_d = (id == LAST_ID) ? '0 : id + 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // neighbour read for the lookup slot entered next cycle
        if (state_d == LOOKUP) begin
            nb_col = col_d;
            nb_row = row_d;
            case (idx_d)
                2'd0:    nb_col = col_d - ONE_S;
                2'd1:    nb_col = col_d + ONE_S;
                2'd2:    nb_row = row_d - ONE_S;
                default: nb_row = row_d + ONE_S;
            endcase
            // an actor outside the maze gets no reads at all
            own_in = (col_d >= ZERO_S) && (col_d < MAZE_W_S) &&
                     (row_d >= ZERO_S) && (row_d < MAZE_H_S);
            nb_in  = (nb_col >= ZERO_S) && (nb_col < MAZE_W_S) &&
                     (nb_row >= ZERO_S) && (nb_row < MAZE_H_S);
            if (own_in && nb_in) begin
                rom_rd_d   = 1'b1;
                rom_addr_d = ADDR_W'(nb_row) * ADDR_W'(MAZE_W) + ADDR_W'(nb_col);
            end
        end

        if (state_d == RESP) begin
            ack_d[id_d] = 1'b1;
            legal_d     = mask_d;
        end

        busy_d = (state_d != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            id              <= '0;
            rr_ptr          <= '0;
            col             <= '0;
            row             <= '0;
            mask            <= '0;
            rd_q            <= 1'b0;
            rd_idx_q        <= '0;
            bus.rom_rd      <= 1'b0;
            bus.rom_addr    <= '0;
            bus.ack         <= '0;
            bus.legal_moves <= '0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_d;
            idx             <= idx_d;
            id              <= id_d;
            rr_ptr          <= rr_ptr_d;
            col             <= col_d;
            row             <= row_d;
            mask            <= mask_d;
            rd_q            <= bus.rom_rd;
            rd_idx_q        <= idx;
            bus.rom_rd      <= rom_rd_d;
            bus.rom_addr    <= rom_addr_d;
            bus.ack         <= ack_d;
            bus.legal_moves <= legal_d;
            bus.busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_maze_access_arbiter.sv
// Scoreboard bench for maze_access_arbiter: expected acks/masks are queued at
// request time from a tile-level maze model and popped when ack appears.
`timescale 1ns/1ps
module tb_maze_access_arbiter;
    localparam int NREQ = 5;
    localparam int AW   = 10;
    localparam int MW   = 28;
    localparam int MH   = 31;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic wall [1024];

    typedef struct packed {
        logic [4:0] ack;
        logic [3:0] mask;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maze_access_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW)) a_if ();
    maze_access_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW)) b_if ();

    maze_access_arbiter #(
        .NREQ(NREQ), .MAZE_W(MW), .MAZE_H(MH), .TILE_SHIFT(3),
        .X_ORG(0), .Y_ORG(0), .ADDR_W(AW)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );

    maze_access_arbiter #(
        .NREQ(NREQ), .MAZE_W(MW), .MAZE_H(MH), .TILE_SHIFT(3),
        .X_ORG(8), .Y_ORG(0), .ADDR_W(AW)
    ) u_dut_org (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    // ROM: wall bit one cycle after a read, noise otherwise
    always @(posedge clk) begin
        a_if.rom_data <= a_if.rom_rd ? wall[a_if.rom_addr] : 1'($urandom % 2);
        b_if.rom_data <= b_if.rom_rd ? wall[b_if.rom_addr] : 1'($urandom % 2);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_mask(input int x, input int y, input int xo, input int yo);
        int c;
        int r;
        logic [3:0] m;
        c = (x - xo) >>> 3;
        r = (y - yo) >>> 3;
        m = 4'b0000;
        if (c < 0 || c >= MW || r < 0 || r >= MH) return m;
        m[0] = (c > 0)      && !wall[r*MW + c - 1];
        m[1] = (c < MW - 1) && !wall[r*MW + c + 1];
        m[2] = (r > 0)      && !wall[(r-1)*MW + c];
        m[3] = (r < MH - 1) && !wall[(r+1)*MW + c];
        return m;
    endfunction

    task automatic set_pos(input int i, input int x, input int y);
        a_if.xpos_bus[i*10 +: 10] = 10'(x);
        a_if.ypos_bus[i*10 +: 10] = 10'(y);
    endtask

    task automatic push_exp(input int i, input int x, input int y);
        exp_t e;
        e.ack  = 5'(1 << i);
        e.mask = ref_mask(x, y, 0, 0);
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int n = 0; n < 30 && !ok; n++) begin
            @(negedge clk);
            if (a_if.ack != '0) begin
                ok = 1'b1;
                at = cyc;
            end
        end
        if (!ok) check("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic rand_pos(output int x, output int y);
        x = int'($urandom_range(0, MW - 1)) * 8 + int'($urandom_range(0, 7));
        y = int'($urandom_range(0, MH - 1)) * 8 + int'($urandom_range(0, 7));
    endtask

    // scoreboard: every ack must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && a_if.ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(a_if.ack), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("ack_id", 32'(a_if.ack), 32'(e.ack));
                check("legal_moves", 32'(a_if.legal_moves), 32'(e.mask));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int t;
        int prev;
        int pulses;
        int px [5];
        int py [5];
        int ea [4];
        logic [4:0] ord;

        rst = 1'b1;
        a_if.req = '0; a_if.xpos_bus = '0; a_if.ypos_bus = '0;
        b_if.req = '0; b_if.xpos_bus = '0; b_if.ypos_bus = '0;
        for (int i = 0; i < 1024; i++) wall[i] = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(a_if.busy), 32'(0));
        check("rst_ack", 32'(a_if.ack), 32'(0));
        check("rst_moves", 32'(a_if.legal_moves), 32'(0));
        check("rst_rom_rd", 32'(a_if.rom_rd), 32'(0));
        check("rst_rom_addr", 32'(a_if.rom_addr), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single lookup at tile (2,2), walls at (1,2) and (2,3)
        wall[57] = 1'b1;
        wall[86] = 1'b1;
        ea = '{57, 59, 30, 86};
        set_pos(0, 16, 16);
        push_exp(0, 16, 16);
        a_if.req = 5'b00001;
        g = cyc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) a_if.req = '0;
            check("t1_rom_rd", 32'(a_if.rom_rd), 32'(1));
            check("t1_rom_addr", 32'(a_if.rom_addr), 32'(ea[k]));
        end
        wait_ack(t);
        check("t1_latency", 32'(t - g), 32'(6));
        check("t1_moves", 32'(a_if.legal_moves), 32'(4'b0110));
        @(negedge clk);
        check("t1_ack_clear", 32'(a_if.ack), 32'(0));
        check("t1_moves_clear", 32'(a_if.legal_moves), 32'(0));
        check("t1_busy_clear", 32'(a_if.busy), 32'(0));

        // corner tile (0,0): left and up clipped
        wall[57] = 1'b0;
        wall[86] = 1'b0;
        ea = '{0, 1, 0, 28};
        set_pos(0, 0, 0);
        push_exp(0, 0, 0);
        a_if.req = 5'b00001;
        g = cyc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) a_if.req = '0;
            check("t2_rom_rd", 32'(a_if.rom_rd), 32'(k % 2));
            if (k % 2 == 1) check("t2_rom_addr", 32'(a_if.rom_addr), 32'(ea[k]));
        end
        wait_ack(t);
        check("t2_latency", 32'(t - g), 32'(6));
        check("t2_moves", 32'(a_if.legal_moves), 32'(4'b1010));

        // round-robin with random walls
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MW * MH; i++) wall[i] = ($urandom % 3 == 0);
        for (int i = 0; i < 5; i++) rand_pos(px[i], py[i]);
        for (int i = 0; i < 5; i++) set_pos(i, px[i], py[i]);
        push_exp(0, px[0], py[0]);
        push_exp(2, px[2], py[2]);
        push_exp(4, px[4], py[4]);
        a_if.req = 5'b10101;
        g = cyc;
        prev = 0;
        for (int n = 0; n < 3; n++) begin
            wait_ack(t);
            ord = 5'(1 << (2 * n));
            check("rr_order", 32'(a_if.ack), 32'(ord));
            if (n == 0) check("rr_latency", 32'(t - g), 32'(6));
            else check("rr_gap", 32'(t - prev), 32'(7));
            prev = t;
            a_if.req = a_if.req & ~a_if.ack;
        end
        for (int i = 0; i < 5; i++) rand_pos(px[i], py[i]);
        set_pos(0, px[0], py[0]);
        set_pos(2, px[2], py[2]);
        push_exp(0, px[0], py[0]);
        push_exp(2, px[2], py[2]);
        a_if.req = 5'b00101;
        for (int n = 0; n < 2; n++) begin
            wait_ack(t);
            ord = 5'(1 << (2 * n));
            check("rr2_order", 32'(a_if.ack), 32'(ord));
            if (n == 1) check("rr2_gap", 32'(t - prev), 32'(7));
            prev = t;
            a_if.req = a_if.req & ~a_if.ack;
        end

        // position latched at grant; req dropped mid-lookup
        @(negedge clk);
        set_pos(3, 43, 46);
        push_exp(3, 43, 46);
        a_if.req = 5'b01000;
        g = cyc;
        @(negedge clk);
        a_if.req = '0;
        set_pos(3, 130, 200);
        wait_ack(t);
        check("t4_latency", 32'(t - g), 32'(6));
        repeat (12) @(negedge clk);
        check("t4_busy", 32'(a_if.busy), 32'(0));

        // reset during LOOKUP idx 2 aborts without ack
        set_pos(2, 80, 80);
        a_if.req = 5'b00100;
        @(negedge clk);
        a_if.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_busy", 32'(a_if.busy), 32'(0));
        check("t5_ack", 32'(a_if.ack), 32'(0));
        check("t5_rom_rd", 32'(a_if.rom_rd), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_pos(px[0], py[0]);
        rand_pos(px[4], py[4]);
        set_pos(0, px[0], py[0]);
        set_pos(4, px[4], py[4]);
        push_exp(0, px[0], py[0]);
        push_exp(4, px[4], py[4]);
        a_if.req = 5'b10001;
        wait_ack(t);
        check("t5_first_grant", 32'(a_if.ack), 32'(5'b00001));
        a_if.req = a_if.req & ~a_if.ack;
        wait_ack(t);
        a_if.req = a_if.req & ~a_if.ack;

        // below-origin actor on the X_ORG=8 instance
        @(negedge clk);
        b_if.xpos_bus[9:0] = 10'd4;
        b_if.ypos_bus[9:0] = 10'd16;
        b_if.req = 5'b00001;
        pulses = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) b_if.req = '0;
            pulses += int'(b_if.rom_rd);
            if (k == 5) check("t6_no_early_ack", 32'(b_if.ack), 32'(0));
        end
        check("t6_ack", 32'(b_if.ack), 32'(5'b00001));
        check("t6_moves", 32'(b_if.legal_moves), 32'(ref_mask(4, 16, 8, 0)));
        check("t6_moves_zero", 32'(b_if.legal_moves), 32'(0));
        check("t6_rom_pulses", 32'(pulses), 32'(0));

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
